// File: rtl/xgcd_quot_approx_pkg.sv
`default_nettype none
// ============================================================================
// Package : xgcd_quot_approx_pkg
// Shared types, range limits and the reciprocal-product LUT value function.
// Revision: 1.0
// ============================================================================
package xgcd_quot_approx_pkg;

  localparam int QA_AB_MIN = 2;
  localparam int QA_AB_MAX = 6;

  // Control flags that travel through the pipeline next to each datum.
  typedef struct packed {
    logic valid;
    logic a_zero;
    logic div_zero;
  } qa_stage_t;

  function automatic bit qa_ab_in_range(input int ab);
    return (ab >= QA_AB_MIN) && (ab <= QA_AB_MAX);
  endfunction

  // Normalised mantissas i, j (MSB set); result is floor((i << ab) / j).
  function automatic int qa_lut_val(input int i, input int j, input int ab);
    if (j == 0) return 0;
    return (i << ab) / j;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xgcd_lzd.sv
`default_nettype none
// ============================================================================
// Module  : xgcd_lzd
// Combinational leading-one index and all-zero flag.
// Revision: 1.0
// ============================================================================
module xgcd_lzd #(
  parameter int WIDTH = 64,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (val_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign zero_o = ~|val_i;

endmodule
`default_nettype wire

// File: rtl/xgcd_quot_approx.sv
`default_nettype none
// ============================================================================
// Module  : xgcd_quot_approx
// 3-stage pipelined floor(a/b) estimator (normalise, LUT, rescale) with
// valid/ready handshakes. Optional XGCD_QA_STATS_EN adds handshake counters.
// Revision: 1.0
// ============================================================================
module xgcd_quot_approx
  import xgcd_quot_approx_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int APPROX_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] q_est_o,
  output logic             div_zero_o
`ifdef XGCD_QA_STATS_EN
  ,
  output logic [31:0]      op_count_o,
  output logic [31:0]      dz_count_o
`endif
);

  localparam int AB        = APPROX_BITS;
  localparam int LUT_W     = AB + 1;
  localparam int IDX_W     = $clog2(WIDTH);
  localparam int SH_W      = $clog2(WIDTH) + 2;
  localparam int ADDR_W    = 2 * AB - 2;
  localparam int LUT_DEPTH = 1 << ADDR_W;
  localparam int HALF      = 1 << (AB - 1);

  generate
    if (!qa_ab_in_range(AB) || (WIDTH < AB)) begin : g_bad_cfg
      $error("xgcd_quot_approx: APPROX_BITS must be 2..6 and <= WIDTH");
    end
  endgenerate

  // Implicit leading one of both mantissas is dropped from the address.
  logic [LUT_W-1:0] lut [LUT_DEPTH];
  generate
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
      localparam int AI = (k >> (AB - 1)) + HALF;
      localparam int BI = (k % HALF) + HALF;
      assign lut[k] = LUT_W'(qa_lut_val(AI, BI, AB));
    end
  endgenerate

  logic adv;
  logic out_valid_q;

  assign adv        = !out_valid_q || out_ready_i;
  assign in_ready_o = adv;

  // ---------------- S1: leading-one detect and normalise ----------------
  logic [IDX_W-1:0] la, lb;
  logic             a_zero, b_zero;
  logic [WIDTH-1:0] a_norm, b_norm;
  qa_stage_t        s1_d, s1_q;
  logic [AB-1:0]    a_top_d, b_top_d, a_top_q, b_top_q;
  logic [IDX_W-1:0] la_q, lb_q;

  xgcd_lzd #(.WIDTH(WIDTH)) u_lzd_a (.val_i(a_i), .idx_o(la), .zero_o(a_zero));
  xgcd_lzd #(.WIDTH(WIDTH)) u_lzd_b (.val_i(b_i), .idx_o(lb), .zero_o(b_zero));

  assign a_norm  = a_i << (IDX_W'(WIDTH - 1) - la);
  assign b_norm  = b_i << (IDX_W'(WIDTH - 1) - lb);
  assign a_top_d = AB'(a_norm >> (WIDTH - AB));
  assign b_top_d = AB'(b_norm >> (WIDTH - AB));

  always_comb begin
    s1_d          = '0;
    s1_d.valid    = in_valid_i;
    s1_d.a_zero   = a_zero;
    s1_d.div_zero = b_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      a_top_q <= '0;
      b_top_q <= '0;
      la_q    <= '0;
      lb_q    <= '0;
    end else if (adv) begin
      s1_q    <= s1_d;
      a_top_q <= a_top_d;
      b_top_q <= b_top_d;
      la_q    <= la;
      lb_q    <= lb;
    end
  end

  // ---------------- S2: LUT lookup and exponent ----------------
  logic [ADDR_W-1:0] addr;
  logic [LUT_W-1:0]  mant_d, mant_q;
  logic [SH_W-1:0]   sh_d, sh_q;
  qa_stage_t         s2_q;

  assign addr   = {a_top_q[AB-2:0], b_top_q[AB-2:0]};
  assign mant_d = lut[addr];
  // Two's-complement in SH_W bits; MSB is the sign.
  assign sh_d   = {2'b00, la_q} - {2'b00, lb_q} - SH_W'(AB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_q   <= '0;
      mant_q <= '0;
      sh_q   <= '0;
    end else if (adv) begin
      s2_q   <= s1_q;
      mant_q <= mant_d;
      sh_q   <= sh_d;
    end
  end

  // ---------------- S3: rescale ----------------
  logic [WIDTH+LUT_W-1:0] wide_l;
  logic [SH_W-1:0]        neg_amt;
  logic [LUT_W-1:0]       shr;
  logic [WIDTH-1:0]       q_d, q_q;
  logic                   dz_q;

  assign wide_l  = {{WIDTH{1'b0}}, mant_q} << sh_q;
  assign neg_amt = -sh_q;
  assign shr     = mant_q >> neg_amt;

  always_comb begin
    q_d = '0;
    if (s2_q.a_zero || s2_q.div_zero) begin
      q_d = '0;
    end else if (!sh_q[SH_W-1]) begin
      q_d = (|wide_l[WIDTH+LUT_W-1:WIDTH]) ? '1 : wide_l[WIDTH-1:0];
    end else if (neg_amt < SH_W'(LUT_W)) begin
      q_d = WIDTH'(shr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dz_q        <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_q.valid;
      q_q         <= q_d;
      dz_q        <= s2_q.div_zero;
    end
  end

  assign out_valid_o = out_valid_q;
  assign q_est_o     = q_q;
  assign div_zero_o  = dz_q;

`ifdef XGCD_QA_STATS_EN
  logic [31:0] op_cnt_q, dz_cnt_q;
  logic        out_hs;

  assign out_hs = out_valid_q && out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q <= '0;
      dz_cnt_q <= '0;
    end else if (out_hs) begin
      op_cnt_q <= op_cnt_q + 32'd1;
      if (dz_q) dz_cnt_q <= dz_cnt_q + 32'd1;
    end
  end

  assign op_count_o = op_cnt_q;
  assign dz_count_o = dz_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xgcd_quot_approx.sv
`default_nettype none
// ============================================================================
// Testbench : tb_xgcd_quot_approx
// Scoreboarded directed and random checks for the quotient estimator.
// Revision  : 1.0
// ============================================================================
module tb_xgcd_quot_approx;

  localparam int W  = 16;
  localparam int AB = 3;

  typedef struct packed {
    logic         dz;
    logic [W-1:0] q;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] q_est;
  logic         div_zero;
`ifdef XGCD_QA_STATS_EN
  logic [31:0]  op_count;
  logic [31:0]  dz_count;
`endif

  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 0;
  logic rdy_fix = 1'b1;
  exp_t sb[$];
  exp_t mon_e;

  xgcd_quot_approx #(.WIDTH(W), .APPROX_BITS(AB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .q_est_o    (q_est),
`ifdef XGCD_QA_STATS_EN
    .op_count_o (op_count),
    .dz_count_o (dz_count),
`endif
    .div_zero_o (div_zero)
  );

  always #5 clk = ~clk;

  // Consumer: fixed, toggling or random readiness.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = rdy_fix;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   r;
    int     la, lb, at, bt, mant, sh;
    longint wide;
    r.dz = (y == 0);
    r.q  = '0;
    if (x == 0 || y == 0) return r;
    la = 0;
    lb = 0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) la = i;
      if (y[i]) lb = i;
    end
    at   = (la >= AB - 1) ? (int'(x) >> (la - AB + 1)) : (int'(x) << (AB - 1 - la));
    bt   = (lb >= AB - 1) ? (int'(y) >> (lb - AB + 1)) : (int'(y) << (AB - 1 - lb));
    mant = (at << AB) / bt;
    sh   = la - lb - AB;
    if (sh >= 0) begin
      wide = longint'(mant) << sh;
      r.q  = (wide > longint'((1 << W) - 1)) ? '1 : W'(wide);
    end else if (-sh >= AB + 1) begin
      r.q = '0;
    end else begin
      r.q = W'(mant >> (-sh));
    end
    return r;
  endfunction

  // Monitor: handshake ordering and in_ready/adv relation.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      assert (in_ready === (!out_valid || out_ready)) else begin
        fails++;
        $error("FAIL in_ready_adv: observed %b expected %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $error("FAIL unexpected_output: observed q=%h dz=%b expected no output", q_est, div_zero);
        end else begin
          mon_e = sb.pop_front();
          assert ({div_zero, q_est} === mon_e) else begin
            fails++;
            $error("FAIL result: observed dz=%b q=%h expected dz=%b q=%h",
                   div_zero, q_est, mon_e.dz, mon_e.q);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int   n;
    logic acc;
    in_valid = 1'b1;
    a = x;
    b = y;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) sb.push_back(e);
    else begin
      tests++;
      fails++;
      $error("FAIL accept_timeout: observed in_ready=0 expected accept within 200 cycles");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    send_exp(x, y, model(x, y));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    return W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
  endfunction

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q_est", 32'(q_est), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    send_exp(16'h0060, 16'h0005, '{dz: 1'b0, q: 16'd18});
    @(posedge clk); #1;
    check("latency_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_3", 32'(out_valid), 32'd1);
    check("latency_q", 32'(q_est), 32'd18);
    drain();

    send_exp(16'h8000, 16'h8000, '{dz: 1'b0, q: 16'd1});
    send_exp(16'h0005, 16'h0060, '{dz: 1'b0, q: 16'd0});
    send_exp(16'h1234, 16'h0000, '{dz: 1'b1, q: 16'd0});
    send_exp(16'h0000, 16'h0007, '{dz: 1'b0, q: 16'd0});
    send_exp(16'h0000, 16'h0000, '{dz: 1'b1, q: 16'd0});
    send_exp(16'hFFFF, 16'h0001, '{dz: 1'b0, q: 16'hE000});
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op() | 16'h0001);
    drain();

    // Fill the stalled pipeline, then reset asynchronously mid-cycle.
    rdy_mode = 0;
    rdy_fix  = 1'b0;
    @(posedge clk); #2;
    send(16'h0100, 16'h0003);
    send(16'h0200, 16'h0005);
    send(16'h0300, 16'h0007);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_q_est", 32'(q_est), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rdy_fix = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);

`ifdef XGCD_QA_STATS_EN
    check("stats_rst_op", op_count, 32'd0);
    check("stats_rst_dz", dz_count, 32'd0);
    send(16'h0040, 16'h0003);
    send(16'h0040, 16'h0000);
    send(16'h7777, 16'h0011);
    send(16'h0000, 16'h0000);
    send(16'h0009, 16'h0002);
    drain();
    check("stats_op", op_count, 32'd5);
    check("stats_dz", dz_count, 32'd2);
    rst = 1'b1;
    #1;
    check("stats_clr_op", op_count, 32'd0);
    check("stats_clr_dz", dz_count, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
`endif

    rdy_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      send(rnd_op(), ($urandom_range(0, 15) == 0) ? 16'h0000 : rnd_op());
    end
    rdy_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
